// File: rtl/bp_me_stream_ordered_merge.sv
// Ordered merge of several BedRock responder streams into one output stream.
// A FIFO of responder ids records the order in which responses are expected.
// The head id selects which source is routed to the output. A source stays
// selected for the whole message and is released only when its last beat is
// accepted downstream.
module bp_me_stream_ordered_merge #(
    // 0 selects the default processor configuration (40-bit physical address)
    parameter int unsigned bp_params_p     = 0,
    parameter int unsigned data_width_p    = 64,
    parameter int unsigned payload_width_p = 8,
    parameter int unsigned num_source_p    = 2,
    parameter int unsigned els_p           = 2,
    localparam int unsigned paddr_width_lp = (bp_params_p == 0) ? 40 : 56,
    // BedRock header: msg_type(4) + subop(4) + addr + size(3) + payload
    localparam int unsigned hdr_width_lp   = 11 + paddr_width_lp + payload_width_p,
    localparam int unsigned src_width_lp   = (num_source_p > 1) ? $clog2(num_source_p) : 1,
    localparam int unsigned cnt_width_lp   = $clog2(els_p + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,

    input  logic                                   track_v_i,
    input  logic [src_width_lp-1:0]                track_src_i,
    output logic                                   track_ready_and_o,

    input  logic [num_source_p*hdr_width_lp-1:0]   msg_header_i,
    input  logic [num_source_p*data_width_p-1:0]   msg_data_i,
    input  logic [num_source_p-1:0]                msg_v_i,
    input  logic [num_source_p-1:0]                msg_last_i,
    output logic [num_source_p-1:0]                msg_ready_and_o,

    output logic [hdr_width_lp-1:0]                msg_header_o,
    output logic [data_width_p-1:0]                msg_data_o,
    output logic                                   msg_v_o,
    output logic                                   msg_last_o,
    input  logic                                   msg_ready_and_i,

    output logic [cnt_width_lp-1:0]                outstanding_o
);

    localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

    logic [src_width_lp-1:0] r_ids [els_p];
    logic [ptr_width_lp-1:0] r_rptr;
    logic [ptr_width_lp-1:0] r_wptr;
    logic [cnt_width_lp-1:0] r_count;

    logic                    w_empty;
    logic                    w_full;
    logic [src_width_lp-1:0] w_head;
    logic                    w_push;
    logic                    w_pop;

    function automatic logic [ptr_width_lp-1:0] f_next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // Occupancy flags and the currently selected responder id
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == full_cnt_lp);
        w_head  = r_ids[r_rptr];
    end

    // Route the head source to the output; everything idle when nothing is tracked
    always_comb begin
        msg_header_o    = '0;
        msg_data_o      = '0;
        msg_v_o         = 1'b0;
        msg_last_o      = 1'b0;
        msg_ready_and_o = '0;
        for (int unsigned i = 0; i < num_source_p; i++) begin
            if (!w_empty && (w_head == src_width_lp'(i))) begin
                msg_header_o       = msg_header_i[i*hdr_width_lp +: hdr_width_lp];
                msg_data_o         = msg_data_i[i*data_width_p +: data_width_p];
                msg_v_o            = msg_v_i[i];
                msg_last_o         = msg_last_i[i];
                msg_ready_and_o[i] = msg_ready_and_i;
            end
        end
    end

    // Push/pop qualification; a full FIFO refuses pushes even while popping
    always_comb begin
        track_ready_and_o = ~w_full;
        w_push            = track_v_i & ~w_full;
        w_pop             = msg_v_o & msg_ready_and_i & msg_last_o;
        outstanding_o     = r_count;
    end

    // Order FIFO storage, wrapping pointers and occupancy count
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < els_p; i++) begin
                r_ids[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_ids[r_wptr] <= track_src_i;
                r_wptr        <= f_next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_next_ptr(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + cnt_width_lp'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - cnt_width_lp'(1);
            end
        end
    end

    // Tracking an id that names no responder is a usage error
    a_track_src_legal: assert property (
        @(posedge clk_i) disable iff (reset_i)
        track_v_i |-> (32'(track_src_i) < num_source_p)
    );

endmodule

// File: tb/tb_bp_me_stream_ordered_merge.sv
// Randomized scoreboard bench for bp_me_stream_ordered_merge.
// Expected output = messages concatenated in the order their ids were tracked.
module tb_bp_me_stream_ordered_merge;

    localparam int NS  = 3;
    localparam int ELS = 4;
    localparam int DW  = 16;
    localparam int PW  = 8;
    localparam int HW  = 11 + 40 + PW;
    localparam int SW  = 2;
    localparam int CW  = 3;

    typedef struct {
        logic [HW-1:0] hdr;
        logic [DW-1:0] data;
        logic          last;
        int            src;
    } beat_t;

    logic              clk;
    logic              reset_i;
    logic              track_v_i;
    logic [SW-1:0]     track_src_i;
    logic              track_ready_and_o;
    logic [NS*HW-1:0]  msg_header_i;
    logic [NS*DW-1:0]  msg_data_i;
    logic [NS-1:0]     msg_v_i;
    logic [NS-1:0]     msg_last_i;
    logic [NS-1:0]     msg_ready_and_o;
    logic [HW-1:0]     msg_header_o;
    logic [DW-1:0]     msg_data_o;
    logic              msg_v_o;
    logic              msg_last_o;
    logic              msg_ready_and_i;
    logic [CW-1:0]     outstanding_o;

    bp_me_stream_ordered_merge #(
        .bp_params_p    (0),
        .data_width_p   (DW),
        .payload_width_p(PW),
        .num_source_p   (NS),
        .els_p          (ELS)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .track_v_i        (track_v_i),
        .track_src_i      (track_src_i),
        .track_ready_and_o(track_ready_and_o),
        .msg_header_i     (msg_header_i),
        .msg_data_i       (msg_data_i),
        .msg_v_i          (msg_v_i),
        .msg_last_i       (msg_last_i),
        .msg_ready_and_o  (msg_ready_and_o),
        .msg_header_o     (msg_header_o),
        .msg_data_o       (msg_data_o),
        .msg_v_o          (msg_v_o),
        .msg_last_o       (msg_last_o),
        .msg_ready_and_i  (msg_ready_and_i),
        .outstanding_o    (outstanding_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    beat_t src_q[NS][$];
    int    model_count = 0;
    bit    acc_flag = 0;
    bit    fire_flag[NS];
    bit    mid_msg = 0;
    beat_t mon_e;
    bit    mon_pop;

    int trk_pct = 0, srcv_pct = 0, rdy_pct = 0, max_len = 1;
    bit trk_pend = 0;
    int trk_src = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares every accepted output beat and tracks the expected occupancy
    always @(negedge clk) begin
        if (reset_i) begin
            model_count = 0;
            acc_flag    = 0;
            mid_msg     = 0;
            for (int s = 0; s < NS; s++) fire_flag[s] = 0;
            exp_q.delete();
        end else begin
            chk("outstanding", 64'(outstanding_o), 64'(model_count));
            chk("track_ready", 64'(track_ready_and_o), 64'(model_count < ELS));
            if (model_count == 0) begin
                chk("empty_v", 64'(msg_v_o), 64'(0));
                chk("empty_ready", 64'(msg_ready_and_o), 64'(0));
                chk("empty_last", 64'(msg_last_o), 64'(0));
            end
            mon_pop = 0;
            if (msg_v_o && msg_ready_and_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got beat hdr %0h, required none", msg_header_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_hdr", 64'(msg_header_o), 64'(mon_e.hdr));
                    chk("beat_data", 64'(msg_data_o), 64'(mon_e.data));
                    chk("beat_last", 64'(msg_last_o), 64'(mon_e.last));
                    chk("beat_src_ready", 64'(msg_ready_and_o), 64'(1) << mon_e.src);
                    mon_pop = mon_e.last;
                    mid_msg = !mon_e.last;
                end
            end
            for (int s = 0; s < NS; s++) fire_flag[s] = msg_v_i[s] && msg_ready_and_o[s];
            acc_flag    = track_v_i && (model_count < ELS);
            model_count = model_count + int'(acc_flag) - int'(mon_pop);
        end
    end

    task automatic commit(input int s);
        int    len;
        beat_t b;
        len = $urandom_range(max_len, 1);
        for (int k = 0; k < len; k++) begin
            b.hdr  = HW'({$urandom(), $urandom()});
            b.data = DW'($urandom());
            b.last = (k == len - 1);
            b.src  = s;
            src_q[s].push_back(b);
            exp_q.push_back(b);
        end
    endtask

    // Stimulus update, run just after each rising edge
    task automatic drive();
        beat_t tmp;
        if (acc_flag) begin
            commit(trk_src);
            trk_pend = 0;
        end
        for (int s = 0; s < NS; s++) begin
            if (fire_flag[s] && src_q[s].size() > 0) tmp = src_q[s].pop_front();
        end
        if (!trk_pend && ($urandom_range(99) < trk_pct)) begin
            trk_pend = 1;
            trk_src  = $urandom_range(NS - 1);
        end
        track_v_i   = trk_pend;
        track_src_i = SW'(trk_src);
        for (int s = 0; s < NS; s++) begin
            if (src_q[s].size() > 0 && ($urandom_range(99) < srcv_pct)) begin
                msg_v_i[s]                = 1'b1;
                msg_header_i[s*HW +: HW]  = src_q[s][0].hdr;
                msg_data_i[s*DW +: DW]    = src_q[s][0].data;
                msg_last_i[s]             = src_q[s][0].last;
            end else begin
                msg_v_i[s]                = 1'b0;
                msg_header_i[s*HW +: HW]  = HW'({$urandom(), $urandom()});
                msg_data_i[s*DW +: DW]    = DW'($urandom());
                msg_last_i[s]             = 1'($urandom());
            end
        end
        msg_ready_and_i = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int knob_trk[3]  = '{30, 70, 100};
    int knob_srcv[3] = '{20, 60, 100};
    int knob_rdy[3]  = '{0, 50, 100};
    int guard;

    initial begin
        reset_i         = 1'b1;
        track_v_i       = 1'b0;
        track_src_i     = '0;
        msg_header_i    = '0;
        msg_data_i      = '0;
        msg_v_i         = '0;
        msg_last_i      = '0;
        msg_ready_and_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("reset_outstanding", 64'(outstanding_o), 64'(0));
        chk("reset_track_ready", 64'(track_ready_and_o), 64'(1));
        chk("reset_msg_v", 64'(msg_v_o), 64'(0));
        chk("reset_src_ready", 64'(msg_ready_and_o), 64'(0));

        // Fill the order FIFO with no responses flowing
        trk_pct = 100; srcv_pct = 0; rdy_pct = 100; max_len = 1;
        repeat (8) step();
        chk("fill_outstanding", 64'(outstanding_o), 64'(ELS));
        chk("fill_track_ready", 64'(track_ready_and_o), 64'(0));
        trk_pct = 0; srcv_pct = 100;
        step();
        step();
        chk("after_pop_outstanding", 64'(outstanding_o), 64'(ELS - 1));
        chk("after_pop_track_ready", 64'(track_ready_and_o), 64'(1));

        // Randomized segments, including back-pressure and sustained push+pop
        for (int seg = 0; seg < 14; seg++) begin
            trk_pct  = knob_trk[$urandom_range(2)];
            srcv_pct = knob_srcv[$urandom_range(2)];
            rdy_pct  = knob_rdy[$urandom_range(2)];
            max_len  = ($urandom_range(1) == 0) ? 1 : 4;
            if (seg == 3) begin
                trk_pct = 100; srcv_pct = 100; rdy_pct = 100; max_len = 1;
            end
            repeat (120) step();
        end

        // Reset in the middle of a multi-beat message
        trk_pct = 100; srcv_pct = 100; rdy_pct = 100; max_len = 4;
        guard = 0;
        while (!mid_msg && guard < 300) begin
            step();
            guard++;
        end
        if (!mid_msg) begin
            n_cmp++;
            n_err++;
            $display("FAIL mid_msg_timeout: no multi-beat message seen, required one within 300 cycles");
        end
        #2;
        reset_i   = 1'b1;
        track_v_i = 1'b1;
        #1;
        chk("midrst_msg_v", 64'(msg_v_o), 64'(0));
        chk("midrst_outstanding", 64'(outstanding_o), 64'(0));
        chk("midrst_src_ready", 64'(msg_ready_and_o), 64'(0));
        for (int s = 0; s < NS; s++) src_q[s].delete();
        trk_pend = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset_i   = 1'b0;
        track_v_i = 1'b0;
        msg_v_i   = '0;
        #1;
        chk("postrst_outstanding", 64'(outstanding_o), 64'(0));
        chk("postrst_track_ready", 64'(track_ready_and_o), 64'(1));

        for (int seg = 0; seg < 4; seg++) begin
            trk_pct  = knob_trk[$urandom_range(2)];
            srcv_pct = knob_srcv[$urandom_range(2)];
            rdy_pct  = knob_rdy[$urandom_range(2)];
            max_len  = 4;
            repeat (120) step();
        end

        // Drain everything still outstanding
        trk_pct = 0; srcv_pct = 100; rdy_pct = 100;
        guard = 0;
        while ((model_count > 0 || trk_pend || exp_q.size() > 0) && guard < 1000) begin
            step();
            guard++;
        end
        repeat (2) step();
        chk("drain_exp_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_outstanding", 64'(outstanding_o), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
